// File: rtl/ml_ahb_arb_wrr_port.sv
// Weighted round-robin grant for one ML AHB slave port.
// Per-master NONSEQ credits, burst lock on SEQ, global refill once no requester has credit.
//
// state    | meaning
// ST_IDLE  | no owner; owner_q kept as the round-robin pointer
// ST_OWNED | owner_q holds the slave port
module ml_ahb_arb_wrr_port #(
  parameter int NB_MASTER_PORT = 4,
  parameter int PTR_WIDTH      = 2,
  parameter int WEIGHT_WIDTH   = 4
) (
  input  logic                                   hclk,
  input  logic                                   reset,
  input  logic [NB_MASTER_PORT*WEIGHT_WIDTH-1:0] weight,
  input  logic [NB_MASTER_PORT-1:0]              mx_sel,
  input  logic [NB_MASTER_PORT-1:0]              mx_htrans0,
  input  logic                                   hready,
  output logic [NB_MASTER_PORT-1:0]              mx_arb_grant,
  output logic [PTR_WIDTH-1:0]                   grant_idx,
  output logic                                   grant_valid,
  output logic                                   refill
);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t                      state_q, state_d;
  logic [PTR_WIDTH-1:0]        owner_q, owner_d;
  logic [WEIGHT_WIDTH-1:0]     credit_q    [NB_MASTER_PORT];
  logic [WEIGHT_WIDTH-1:0]     credit_d    [NB_MASTER_PORT];
  logic [WEIGHT_WIDTH-1:0]     credit_post [NB_MASTER_PORT];
  logic [NB_MASTER_PORT-1:0]   grant_q, grant_d;
  logic                        refill_q, refill_d;
  logic                        ov, consume, lock, keep;
  logic [WEIGHT_WIDTH-1:0]     owner_credit, owner_credit_dec;
  logic [NB_MASTER_PORT-1:0]   eligible;

  // First set bit of vec searching cyclically from last+1; last itself is tried last.
  function automatic logic [PTR_WIDTH-1:0] rr_pick(input logic [NB_MASTER_PORT-1:0] vec,
                                                   input logic [PTR_WIDTH-1:0] last);
    logic [PTR_WIDTH-1:0] pick;
    logic [PTR_WIDTH-1:0] idx_p;
    logic                 found;
    int                   idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NB_MASTER_PORT; k++) begin
      idx   = (int'(last) + k) % NB_MASTER_PORT;
      idx_p = PTR_WIDTH'(idx);
      if (!found && vec[idx_p]) begin
        pick  = idx_p;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign ov               = (state_q == ST_OWNED);
  assign owner_credit     = credit_q[owner_q];
  assign consume          = ov & mx_sel[owner_q] & ~mx_htrans0[owner_q] & (owner_credit != '0);
  assign lock             = ov & mx_sel[owner_q] & mx_htrans0[owner_q];
  assign owner_credit_dec = owner_credit - WEIGHT_WIDTH'(consume);
  assign keep             = lock | (ov & mx_sel[owner_q] & (owner_credit_dec != '0));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    refill_d = 1'b0;
    eligible = '0;
    for (int i = 0; i < NB_MASTER_PORT; i++) begin
      credit_d[i]    = credit_q[i];
      credit_post[i] = credit_q[i];
    end
    credit_post[owner_q] = owner_credit_dec;
    for (int i = 0; i < NB_MASTER_PORT; i++)
      eligible[i] = mx_sel[i] & (credit_post[i] != '0);

    if (hready) begin
      for (int i = 0; i < NB_MASTER_PORT; i++)
        credit_d[i] = credit_post[i];
      if (keep) begin
        state_d = ST_OWNED;
      end else if (|eligible) begin
        owner_d = rr_pick(eligible, owner_q);
        state_d = ST_OWNED;
      end else if (|mx_sel) begin
        // refill overrides this cycle's consume; zero weight behaves as one
        for (int i = 0; i < NB_MASTER_PORT; i++) begin
          credit_d[i] = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
          if (credit_d[i] == '0)
            credit_d[i] = WEIGHT_WIDTH'(1);
        end
        owner_d  = rr_pick(mx_sel, owner_q);
        state_d  = ST_OWNED;
        refill_d = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    grant_d = '0;
    if (state_d == ST_OWNED)
      grant_d[owner_d] = 1'b1;
  end

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= PTR_WIDTH'(NB_MASTER_PORT - 1);
      grant_q  <= '0;
      refill_q <= 1'b0;
      for (int i = 0; i < NB_MASTER_PORT; i++)
        credit_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      refill_q <= refill_d;
      for (int i = 0; i < NB_MASTER_PORT; i++)
        credit_q[i] <= credit_d[i];
    end
  end

  assign mx_arb_grant = grant_q;
  assign grant_idx    = owner_q;
  assign grant_valid  = |grant_q;
  assign refill       = refill_q;

endmodule

// File: tb/tb_ml_ahb_arb_wrr_port.sv
// Directed bench for ml_ahb_arb_wrr_port: the driver queues hand-computed
// expectations per edge, a negedge monitor pops and compares them.
module tb_ml_ahb_arb_wrr_port;

  logic        hclk = 1'b0;
  logic        reset;
  logic [15:0] weight;
  logic [3:0]  mx_sel;
  logic [3:0]  mx_htrans0;
  logic        hready;
  logic [3:0]  mx_arb_grant;
  logic [1:0]  grant_idx;
  logic        grant_valid;
  logic        refill;

  typedef struct packed {
    logic [3:0]  grant;
    logic [1:0]  idx;
    logic        refill;
    logic [15:0] step_no;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   step_no = 0;

  ml_ahb_arb_wrr_port #(
    .NB_MASTER_PORT(4),
    .PTR_WIDTH     (2),
    .WEIGHT_WIDTH  (4)
  ) dut (
    .hclk        (hclk),
    .reset       (reset),
    .weight      (weight),
    .mx_sel      (mx_sel),
    .mx_htrans0  (mx_htrans0),
    .hready      (hready),
    .mx_arb_grant(mx_arb_grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .refill      (refill)
  );

  always #5 hclk = ~hclk;

  // expected state after the edge that samples these inputs
  task automatic step(input logic [3:0] sel, input logic [3:0] ht, input logic rdy,
                      input logic [3:0] eg, input logic [1:0] ei, input logic er);
    exp_t e;
    mx_sel     = sel;
    mx_htrans0 = ht;
    hready     = rdy;
    @(posedge hclk);
    step_no++;
    e.grant   = eg;
    e.idx     = ei;
    e.refill  = er;
    e.step_no = 16'(step_no);
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge hclk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (mx_arb_grant !== mon_e.grant || grant_idx !== mon_e.idx ||
          grant_valid !== (|mon_e.grant) || refill !== mon_e.refill) begin
        errors++;
        $display("FAIL step %0d: got grant=%b idx=%0d valid=%b refill=%b, want grant=%b idx=%0d valid=%b refill=%b",
                 mon_e.step_no, mx_arb_grant, grant_idx, grant_valid, refill,
                 mon_e.grant, mon_e.idx, |mon_e.grant, mon_e.refill);
      end
    end
  end

  task automatic check_reset(input int id);
    checks++;
    if (mx_arb_grant !== 4'b0000 || grant_idx !== 2'd3 || grant_valid !== 1'b0 || refill !== 1'b0) begin
      errors++;
      $display("FAIL reset_%0d: got grant=%b idx=%0d valid=%b refill=%b, want grant=0000 idx=3 valid=0 refill=0",
               id, mx_arb_grant, grant_idx, grant_valid, refill);
    end
  endtask

  // asynchronous assert away from any edge, checked before the next edge
  task automatic do_reset(input int id);
    @(negedge hclk);
    #1;
    reset = 1'b1;
    #1;
    check_reset(id);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    mx_sel     = 4'b0000;
    mx_htrans0 = 4'b0000;
    hready     = 1'b1;
    weight     = 16'h0200;
    #3;
    check_reset(0);
    @(negedge hclk);
    #4;
    reset = 1'b0;

    // single requester, weight 2: refill every second edge
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1);
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1);
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1);
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0);
    // idle keeps pointer; leftover credit 1 lets re-request win without refill
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1);
    // stall right after a refill: refill drops, all else holds
    step(4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1);

    // burst lock with weights 1,1
    do_reset(1);
    weight = 16'h0011;
    step(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1);
    step(4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0);
    step(4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1);
    step(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0);
    do_reset(2);
    step(4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1);

    // weighted sharing 3:0(=1), stall, then weight[0] 3->1 mid-epoch
    do_reset(3);
    weight = 16'h0003;
    step(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1);
    step(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0);
    step(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(4'b0011, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0);
    step(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1);
    weight = 16'h0001;
    step(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0);
    step(4'b0011, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0);
    step(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1);
    step(4'b0011, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0);
    step(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1);
    step(4'b0011, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      @(negedge hclk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
